// File: rtl/calc_pkg.sv
// Shared types for the calculator queue: command codes, ALU opcodes, error and state encodings.
// Pure declarations; no timing or flow control of its own.
package calc_pkg;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    typedef enum logic [1:0] {
        Q_PUSH         = 2'b00,
        Q_SLEEP        = 2'b01,
        Q_GET_AND_PUSH = 2'b10,
        Q_POP          = 2'b11
    } qop_e;

    typedef enum logic [2:0] {
        PUSH = 3'd0,
        ADD  = 3'd1,
        SUB  = 3'd2,
        MUL  = 3'd3,
        DIV  = 3'd4,
        REM  = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_UNDER = 2'd1,
        ERR_OVER  = 2'd2,
        ERR_CALC  = 2'd3
    } err_e;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

endpackage

// File: rtl/calc_queue_if.sv
// ALU <-> queue bundle: single-cycle qualified command in, operand/status view out.
// No backpressure; commands arriving while halted are dropped by the queue.
interface calc_queue_if #(
    parameter int PTR_W = calc_pkg::PTR_W
);
    logic             op_valid;
    logic [1:0]       queue_op;
    logic [7:0]       result;
    logic             has_calc_err;
    logic             err_clr;
    logic [15:0]      operands;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             halted;
    logic [1:0]       err_code;

    modport master (
        output op_valid, queue_op, result, has_calc_err, err_clr,
        input  operands, count, empty, full, halted, err_code
    );

    modport slave (
        input  op_valid, queue_op, result, has_calc_err, err_clr,
        output operands, count, empty, full, halted, err_code
    );
endinterface

// File: rtl/calc_queue_mem.sv
// DEPTH x 8 register file, one synchronous write port, two combinational read ports.
// Write visible one cycle later; reads have zero latency; no backpressure.
module calc_queue_mem #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic [PTR_W-1:0] raddr0_i,
    input  logic [PTR_W-1:0] raddr1_i,
    output logic [7:0]       rdata0_o,
    output logic [7:0]       rdata1_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/calc_queue.sv
// Circular operand queue executing ALU queue commands; halts on underflow/overflow/calc error.
// Latency 1 cycle per command; no backpressure, commands seen while halted are dropped.
module calc_queue
    import calc_pkg::*;
#(
    parameter int DEPTH_P = calc_pkg::DEPTH,
    parameter int PTR_W_P = calc_pkg::PTR_W
) (
    input  logic        clk,
    input  logic        rst,
    calc_queue_if.slave bus
);

    localparam logic [PTR_W_P:0] CNT_FULL = (PTR_W_P+1)'(DEPTH_P);

    state_e              state_q, state_d;
    err_e                err_q, err_d;
    logic [PTR_W_P-1:0]  head_q, head_d;
    logic [PTR_W_P-1:0]  tail_q, tail_d;
    logic [PTR_W_P:0]    count_q, count_d;
    logic [PTR_W_P-1:0]  head_nxt;
    logic                we;
    logic [7:0]          rd0, rd1;
    qop_e                op;

    assign op       = qop_e'(bus.queue_op);
    assign head_nxt = head_q + 1'b1;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        we      = 1'b0;

        if (state_q == HALT) begin
            // A command arriving alongside the clear is intentionally dropped.
            if (bus.err_clr) begin
                state_d = RUN;
                err_d   = ERR_NONE;
            end
        end else if (bus.op_valid) begin
            if (bus.has_calc_err) begin
                state_d = HALT;
                err_d   = ERR_CALC;
            end else begin
                case (op)
                    Q_PUSH: begin
                        if (count_q == CNT_FULL) begin
                            state_d = HALT;
                            err_d   = ERR_OVER;
                        end else begin
                            we      = 1'b1;
                            tail_d  = tail_q + 1'b1;
                            count_d = count_q + 1'b1;
                        end
                    end
                    Q_POP: begin
                        if (count_q == '0) begin
                            state_d = HALT;
                            err_d   = ERR_UNDER;
                        end else begin
                            head_d  = head_nxt;
                            count_d = count_q - 1'b1;
                        end
                    end
                    Q_GET_AND_PUSH: begin
                        // Legal when full: the slot written at tail is one of the two consumed.
                        if (count_q < (PTR_W_P+1)'(2)) begin
                            state_d = HALT;
                            err_d   = ERR_UNDER;
                        end else begin
                            we      = 1'b1;
                            head_d  = head_q + PTR_W_P'(2);
                            tail_d  = tail_q + 1'b1;
                            count_d = count_q - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            err_q   <= ERR_NONE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    calc_queue_mem #(
        .DEPTH (DEPTH_P),
        .PTR_W (PTR_W_P)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we),
        .waddr_i  (tail_q),
        .wdata_i  (bus.result),
        .raddr0_i (head_q),
        .raddr1_i (head_nxt),
        .rdata0_o (rd0),
        .rdata1_o (rd1)
    );

    assign bus.operands = {rd1, rd0};
    assign bus.count    = count_q;
    assign bus.empty    = (count_q == '0);
    assign bus.full     = (count_q == CNT_FULL);
    assign bus.halted   = (state_q == HALT);
    assign bus.err_code = err_q;

endmodule
